// File: rtl/pong_if.sv
// Control and display bundle between the game engine and its surroundings.
// The engine takes the slave side; the player inputs and the screen driver take the master side.
interface pong_if #(
    parameter int COLS = 16,
    parameter int ROWS = 16
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    logic          tick;
    logic          p1_up;
    logic          p1_dn;
    logic          p2_up;
    logic          p2_dn;
    logic [XW-1:0] ball_x;
    logic [YW-1:0] ball_y;
    logic [YW-1:0] p1_pos;
    logic [YW-1:0] p2_pos;
    logic [3:0]    score1;
    logic [3:0]    score2;
    logic [1:0]    state;
    logic          game_over;

    modport master (
        output tick, p1_up, p1_dn, p2_up, p2_dn,
        input  ball_x, ball_y, p1_pos, p2_pos, score1, score2, state, game_over
    );

    modport slave (
        input  tick, p1_up, p1_dn, p2_up, p2_dn,
        output ball_x, ball_y, p1_pos, p2_pos, score1, score2, state, game_over
    );
endinterface

// File: rtl/pong_core.sv
// Pong engine: ball motion, two paddles, collisions, scoring and serve/play/game-over sequencing.
// All state advances only on the one-cycle game tick; reset is synchronous and wins over tick.
module pong_core #(
    parameter int COLS        = 16,
    parameter int ROWS        = 16,
    parameter int PADDLE_LEN  = 4,
    parameter int BALLSPEED   = 20,
    parameter int PADDLESPEED = 10,
    parameter int SERVE_DELAY = 500,
    parameter int WIN_SCORE   = 9
) (
    input logic   clk,
    input logic   reset,
    pong_if.slave bus
);
    localparam int XW  = $clog2(COLS);
    localparam int YW  = $clog2(ROWS);
    localparam int BCW = $clog2(BALLSPEED + 1);
    localparam int PCW = $clog2(PADDLESPEED + 1);
    localparam int SCW = $clog2(SERVE_DELAY + 1);

    localparam logic [XW-1:0]  X_MID      = XW'(COLS / 2);
    localparam logic [YW-1:0]  Y_MID      = YW'(ROWS / 2);
    localparam logic [XW-1:0]  X_LEFT     = XW'(1);
    localparam logic [XW-1:0]  X_RIGHT    = XW'(COLS - 2);
    localparam logic [YW-1:0]  Y_MAX      = YW'(ROWS - 1);
    localparam logic [YW-1:0]  PAD_MAX    = YW'(ROWS - PADDLE_LEN);
    localparam logic [YW-1:0]  PAD_HOME   = YW'((ROWS - PADDLE_LEN) / 2);
    localparam logic [YW-1:0]  PAD_SPAN   = YW'(PADDLE_LEN - 1);
    localparam logic [BCW-1:0] BALL_LAST  = BCW'(BALLSPEED - 1);
    localparam logic [PCW-1:0] PAD_LAST   = PCW'(PADDLESPEED - 1);
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_DELAY - 1);
    localparam logic [3:0]     WIN        = 4'(WIN_SCORE);

    typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_e;
    typedef enum logic [1:0] {DY_ZERO = 2'b00, DY_POS = 2'b01, DY_NEG = 2'b11} dy_e;

    state_e         state_q;
    logic [XW-1:0]  ball_x_q;
    logic [YW-1:0]  ball_y_q;
    logic           dx_pos_q;
    dy_e            dy_q;
    dy_e            serve_dy_q;
    logic [YW-1:0]  p1_q;
    logic [YW-1:0]  p2_q;
    logic [3:0]     score1_q;
    logic [3:0]     score2_q;
    logic           game_over_q;
    logic [BCW-1:0] ball_cnt_q;
    logic [PCW-1:0] pad_cnt_q;
    logic [SCW-1:0] serve_cnt_q;

    function automatic dy_e flip(input dy_e d);
        case (d)
            DY_POS:  return DY_NEG;
            DY_NEG:  return DY_POS;
            default: return DY_ZERO;
        endcase
    endfunction

    // Reflect dy off the top/bottom wall so the move never leaves the field.
    function automatic dy_e fold(input logic [YW-1:0] y, input dy_e d);
        if ((y == '0 && d == DY_NEG) || (y == Y_MAX && d == DY_POS)) return flip(d);
        return d;
    endfunction

    function automatic logic [YW-1:0] pad_next(input logic [YW-1:0] pos, input logic up, input logic dn);
        if (up && !dn && pos != '0) return pos - 1'b1;
        if (dn && !up && pos != PAD_MAX) return pos + 1'b1;
        return pos;
    endfunction

    logic          at_p1, at_p2, hit, miss, dx_d;
    logic [YW-1:0] pad_top, pad_bot;
    dy_e           dy_wall, dy_hit, dy_d;
    logic [XW-1:0] ball_x_d;
    logic [YW-1:0] ball_y_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        at_p1   = (ball_x_q == X_LEFT) && !dx_pos_q;
        at_p2   = (ball_x_q == X_RIGHT) && dx_pos_q;
        pad_top = at_p1 ? p1_q : p2_q;
        pad_bot = pad_top + PAD_SPAN;
        hit     = (at_p1 || at_p2) && (ball_y_q >= pad_top) && (ball_y_q <= pad_bot);
        miss    = (at_p1 || at_p2) && !hit;
        dx_d    = hit ? !dx_pos_q : dx_pos_q;
        dy_wall = fold(ball_y_q, dy_q);
        dy_hit  = dy_wall;
        if (hit && ball_y_q == pad_top)      dy_hit = DY_NEG;
        else if (hit && ball_y_q == pad_bot) dy_hit = DY_POS;
        dy_d     = fold(ball_y_q, dy_hit);
        ball_x_d = dx_d ? ball_x_q + 1'b1 : ball_x_q - 1'b1;
        case (dy_d)
            DY_POS:  ball_y_d = ball_y_q + 1'b1;
            DY_NEG:  ball_y_d = ball_y_q - 1'b1;
            default: ball_y_d = ball_y_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SERVE;
            ball_x_q    <= X_MID;
            ball_y_q    <= Y_MID;
            dx_pos_q    <= 1'b1;
            dy_q        <= DY_POS;
            serve_dy_q  <= DY_POS;
            p1_q        <= PAD_HOME;
            p2_q        <= PAD_HOME;
            score1_q    <= '0;
            score2_q    <= '0;
            game_over_q <= 1'b0;
            ball_cnt_q  <= '0;
            pad_cnt_q   <= '0;
            serve_cnt_q <= '0;
        end else if (bus.tick && state_q != S_OVER) begin
            pad_cnt_q <= (pad_cnt_q == PAD_LAST) ? '0 : pad_cnt_q + 1'b1;
            if (pad_cnt_q == PAD_LAST) begin
                p1_q <= pad_next(p1_q, bus.p1_up, bus.p1_dn);
                p2_q <= pad_next(p2_q, bus.p2_up, bus.p2_dn);
            end
            case (state_q)
                S_SERVE: begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_q     <= S_PLAY;
                        serve_cnt_q <= '0;
                        ball_cnt_q  <= '0;
                    end else begin
                        serve_cnt_q <= serve_cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (ball_cnt_q != BALL_LAST) begin
                        ball_cnt_q <= ball_cnt_q + 1'b1;
                    end else if (miss) begin
                        ball_cnt_q  <= '0;
                        ball_x_q    <= X_MID;
                        ball_y_q    <= Y_MID;
                        dx_pos_q    <= at_p2;
                        serve_dy_q  <= flip(serve_dy_q);
                        dy_q        <= flip(serve_dy_q);
                        serve_cnt_q <= '0;
                        if (at_p1) begin
                            score2_q    <= score2_q + 1'b1;
                            state_q     <= (score2_q + 1'b1 == WIN) ? S_OVER : S_SERVE;
                            game_over_q <= (score2_q + 1'b1 == WIN);
                        end else begin
                            score1_q    <= score1_q + 1'b1;
                            state_q     <= (score1_q + 1'b1 == WIN) ? S_OVER : S_SERVE;
                            game_over_q <= (score1_q + 1'b1 == WIN);
                        end
                    end else begin
                        ball_cnt_q <= '0;
                        ball_x_q   <= ball_x_d;
                        ball_y_q   <= ball_y_d;
                        dx_pos_q   <= dx_d;
                        dy_q       <= dy_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.p1_pos    = p1_q;
    assign bus.p2_pos    = p2_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_pong_core.sv
// Bench for pong_core: directed scenarios on a 16x8 field plus a randomized run against
// an arithmetic reference model of the game rules.
module tb_pong_core;
    localparam int COLS = 16, ROWS = 8, PLEN = 3, BSPD = 2, PSPD = 1, SDLY = 4, WIN = 2;
    localparam int XW = $clog2(COLS), YW = $clog2(ROWS);

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pong_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    pong_core #(
        .COLS(COLS), .ROWS(ROWS), .PADDLE_LEN(PLEN), .BALLSPEED(BSPD),
        .PADDLESPEED(PSPD), .SERVE_DELAY(SDLY), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, direction as signed steps, state 0/1/2.
    int m_x, m_y, m_dx, m_dy, m_sdy, m_p1, m_p2, m_s1, m_s2, m_state, m_bc, m_pc, m_sc;

    task automatic model_reset();
        m_x = COLS / 2; m_y = ROWS / 2; m_dx = 1; m_dy = 1; m_sdy = 1;
        m_p1 = (ROWS - PLEN) / 2; m_p2 = (ROWS - PLEN) / 2;
        m_s1 = 0; m_s2 = 0; m_state = 0; m_bc = 0; m_pc = 0; m_sc = 0;
    endtask

    function automatic int paddle_move(input int pos, input bit up, input bit dn);
        if (up && !dn && pos > 0) return pos - 1;
        if (dn && !up && pos < ROWS - PLEN) return pos + 1;
        return pos;
    endfunction

    task automatic model_ball_step();
        int dx = m_dx;
        int dy = m_dy;
        int pad;
        if (m_y + dy < 0 || m_y + dy > ROWS - 1) dy = -dy;
        if (m_x + dx == 0 || m_x + dx == COLS - 1) begin
            pad = (dx < 0) ? m_p1 : m_p2;
            if (m_y >= pad && m_y <= pad + PLEN - 1) begin
                dx = -dx;
                if (m_y == pad) dy = -1;
                else if (m_y == pad + PLEN - 1) dy = 1;
                if (m_y + dy < 0 || m_y + dy > ROWS - 1) dy = -dy;
            end else begin
                if (dx < 0) m_s2++; else m_s1++;
                m_state = (m_s1 == WIN || m_s2 == WIN) ? 2 : 0;
                m_dx = dx;
                m_sdy = -m_sdy;
                m_dy = m_sdy;
                m_x = COLS / 2; m_y = ROWS / 2; m_sc = 0;
                return;
            end
        end
        m_x += dx; m_y += dy; m_dx = dx; m_dy = dy;
    endtask

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        int np1 = m_p1;
        int np2 = m_p2;
        if (m_state == 2) return;
        if (m_pc == PSPD - 1) begin
            np1 = paddle_move(m_p1, u1, d1);
            np2 = paddle_move(m_p2, u2, d2);
        end
        m_pc = (m_pc + 1) % PSPD;
        if (m_state == 0) begin
            if (m_sc == SDLY - 1) begin m_state = 1; m_sc = 0; m_bc = 0; end
            else m_sc++;
        end else begin
            if (m_bc == BSPD - 1) begin m_bc = 0; model_ball_step(); end
            else m_bc++;
        end
        m_p1 = np1; m_p2 = np2;
    endtask

    task automatic set_buttons(input bit u1, input bit d1, input bit u2, input bit d2);
        bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.tick = 1'b0;
        set_buttons(0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.ball_x !== 4'd8 || bus.ball_y !== 3'd4) begin
            errors++; $display("FAIL reset_ball: got (%0d,%0d) want (8,4)", bus.ball_x, bus.ball_y);
        end
        checks++;
        if (bus.p1_pos !== 3'd2 || bus.p2_pos !== 3'd2) begin
            errors++; $display("FAIL reset_paddles: got %0d/%0d want 2/2", bus.p1_pos, bus.p2_pos);
        end
        checks++;
        if (bus.state !== 2'd0 || bus.game_over !== 1'b0 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin
            errors++; $display("FAIL reset_status: got state=%0d go=%0d s1=%0d s2=%0d want 0 0 0 0",
                               bus.state, bus.game_over, bus.score1, bus.score2);
        end
    endtask

    task automatic test_serve_bounce();
        int ex[4] = '{9, 10, 11, 12};
        int ey[4] = '{5, 6, 7, 6};
        do_reset();
        bus.tick = 1'b1;
        run_ticks(3);
        checks++;
        if (bus.state !== 2'd0 || bus.ball_x !== 4'd8) begin
            errors++; $display("FAIL serve_hold: got state=%0d x=%0d want 0 8", bus.state, bus.ball_x);
        end
        run_ticks(1);
        checks++;
        if (bus.state !== 2'd1) begin
            errors++; $display("FAIL serve_to_play: got state=%0d want 1", bus.state);
        end
        for (int i = 0; i < 4; i++) begin
            run_ticks(2);
            checks++;
            if (bus.ball_x !== 4'(ex[i]) || bus.ball_y !== 3'(ey[i])) begin
                errors++; $display("FAIL bounce_step%0d: got (%0d,%0d) want (%0d,%0d)",
                                   i, bus.ball_x, bus.ball_y, ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_paddle_limits();
        int exp2[4] = '{3, 4, 5, 5};
        int exp1[4] = '{1, 0, 0, 0};
        do_reset();
        bus.tick = 1'b1;
        set_buttons(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            run_ticks(1);
            checks++;
            if (bus.p2_pos !== 3'(exp2[i]) || bus.p1_pos !== 3'(exp1[i])) begin
                errors++; $display("FAIL paddle_tick%0d: got p1=%0d p2=%0d want p1=%0d p2=%0d",
                                   i, bus.p1_pos, bus.p2_pos, exp1[i], exp2[i]);
            end
        end
        set_buttons(1, 1, 1, 1);
        run_ticks(3);
        checks++;
        if (bus.p2_pos !== 3'd5 || bus.p1_pos !== 3'd0) begin
            errors++; $display("FAIL paddle_both_held: got p1=%0d p2=%0d want 0/5", bus.p1_pos, bus.p2_pos);
        end
    endtask

    task automatic test_rally_hit();
        do_reset();
        bus.tick = 1'b1;
        run_ticks(16);
        checks++;
        if (bus.ball_x !== 4'd14 || bus.ball_y !== 3'd4) begin
            errors++; $display("FAIL rally_approach: got (%0d,%0d) want (14,4)", bus.ball_x, bus.ball_y);
        end
        run_ticks(2);
        checks++;
        if (bus.ball_x !== 4'd13 || bus.ball_y !== 3'd5 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin
            errors++; $display("FAIL rally_hit: got (%0d,%0d) s=%0d/%0d want (13,5) s=0/0",
                               bus.ball_x, bus.ball_y, bus.score1, bus.score2);
        end
        run_ticks(2);
        checks++;
        if (bus.ball_x !== 4'd12 || bus.ball_y !== 3'd6) begin
            errors++; $display("FAIL rally_return: got (%0d,%0d) want (12,6)", bus.ball_x, bus.ball_y);
        end
    endtask

    task automatic test_miss_and_game_over();
        do_reset();
        bus.tick = 1'b1;
        set_buttons(0, 0, 1, 0);
        run_ticks(18);
        checks++;
        if (bus.score1 !== 4'd1 || bus.ball_x !== 4'd8 || bus.ball_y !== 3'd4 || bus.state !== 2'd0) begin
            errors++; $display("FAIL miss_score: got s1=%0d ball=(%0d,%0d) state=%0d want 1 (8,4) 0",
                               bus.score1, bus.ball_x, bus.ball_y, bus.state);
        end
        set_buttons(0, 0, 0, 1);
        run_ticks(6);
        checks++;
        if (bus.ball_x !== 4'd9 || bus.ball_y !== 3'd3 || bus.state !== 2'd1) begin
            errors++; $display("FAIL serve_direction: got (%0d,%0d) state=%0d want (9,3) 1",
                               bus.ball_x, bus.ball_y, bus.state);
        end
        run_ticks(12);
        checks++;
        if (bus.score1 !== 4'd2 || bus.state !== 2'd2 || bus.game_over !== 1'b1) begin
            errors++; $display("FAIL game_over: got s1=%0d state=%0d go=%0d want 2 2 1",
                               bus.score1, bus.state, bus.game_over);
        end
        for (int i = 0; i < 10; i++) begin
            set_buttons(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            run_ticks(1);
        end
        checks++;
        if (bus.ball_x !== 4'd8 || bus.ball_y !== 3'd4 || bus.p1_pos !== 3'd2 || bus.p2_pos !== 3'd5 ||
            bus.score1 !== 4'd2 || bus.score2 !== 4'd0 || bus.state !== 2'd2) begin
            errors++; $display("FAIL game_over_frozen: got ball=(%0d,%0d) p=%0d/%0d s=%0d/%0d state=%0d want (8,4) 2/5 2/0 2",
                               bus.ball_x, bus.ball_y, bus.p1_pos, bus.p2_pos, bus.score1, bus.score2, bus.state);
        end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        bus.tick = 1'b1;
        set_buttons(0, 1, 1, 0);
        run_ticks(7);
        bus.tick = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.ball_x !== 4'd8 || bus.ball_y !== 3'd4 || bus.p1_pos !== 3'd2 || bus.p2_pos !== 3'd2 ||
            bus.state !== 2'd0 || bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.game_over !== 1'b0) begin
            errors++; $display("FAIL reset_mid_play: got ball=(%0d,%0d) p=%0d/%0d state=%0d want (8,4) 2/2 0",
                               bus.ball_x, bus.ball_y, bus.p1_pos, bus.p2_pos, bus.state);
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit t, u1, d1, u2, d2, r;
            t  = ($urandom_range(3) != 0);
            u1 = 1'($urandom_range(1)); d1 = 1'($urandom_range(1));
            u2 = 1'($urandom_range(1)); d2 = 1'($urandom_range(1));
            r  = (m_state == 2) ? ($urandom_range(7) == 0) : ($urandom_range(299) == 0);
            reset = r; bus.tick = t;
            set_buttons(u1, d1, u2, d2);
            @(posedge clk);
            if (r) model_reset();
            else if (t) model_tick(u1, d1, u2, d2);
            #1;
            checks++;
            if (bus.ball_x !== 4'(m_x) || bus.ball_y !== 3'(m_y) || bus.p1_pos !== 3'(m_p1) ||
                bus.p2_pos !== 3'(m_p2) || bus.score1 !== 4'(m_s1) || bus.score2 !== 4'(m_s2) ||
                bus.state !== 2'(m_state) || bus.game_over !== (m_state == 2)) begin
                errors++;
                $display("FAIL random_cycle%0d: got ball=(%0d,%0d) p=%0d/%0d s=%0d/%0d st=%0d want ball=(%0d,%0d) p=%0d/%0d s=%0d/%0d st=%0d",
                         c, bus.ball_x, bus.ball_y, bus.p1_pos, bus.p2_pos, bus.score1, bus.score2, bus.state,
                         m_x, m_y, m_p1, m_p2, m_s1, m_s2, m_state);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0;
        set_buttons(0, 0, 0, 0);
        run_ticks(2);
        test_reset();
        test_serve_bounce();
        test_paddle_limits();
        test_rally_hit();
        test_miss_and_game_over();
        test_reset_mid_play();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
